// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Holds the FSM state encoding and the pointer-to-mask thermometer.
package arb_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BURST = 2'd2
  } arb_state_e;

  // Bits strictly above ptr are set; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] mask_above(input int ptr);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[i] = (i > ptr);
    return m;
  endfunction

endpackage

// File: rtl/lsb_pick.sv
// Combinational lowest-set-bit picker: one-hot, encoded index and any-set flag.
module lsb_pick #(
  parameter int WIDTH = 8,
  parameter int SIZE  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_oh,
  output logic [SIZE-1:0]  o_enc,
  output logic             o_any
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    o_oh  = '0;
    o_enc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_oh    = '0;
        o_oh[i] = 1'b1;
        o_enc   = SIZE'(i);
      end
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/rr_burst_arbiter.sv
// Registered round-robin arbiter with capped multi-beat bursts toward one port.
// Release re-arbitrates in the same cycle so back-to-back grants have no bubble.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIZE      = $clog2(WIDTH),
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic [WIDTH-1:0] Req,
  input  logic             Last,
  input  logic             GntReady,
  output logic             GntValid,
  output logic [WIDTH-1:0] Gnt,
  output logic [SIZE-1:0]  GntEnc,
  output logic             MultiReq,
  output logic             ForceRel
);

  arb_state_e       r_state;
  logic [SIZE-1:0]  r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [SIZE-1:0]  w_ptr_sel;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_m_oh, w_a_oh, w_pick_oh;
  logic [SIZE-1:0]  w_m_enc, w_a_enc, w_pick_enc;
  logic             w_m_any, w_a_any;
  logic             w_accept, w_cap, w_release, w_multi;

  // Outside IDLE a pick is only consumed on release, where the new pointer is GntEnc.
  assign w_ptr_sel = (r_state == IDLE) ? r_ptr : GntEnc;
  assign w_mask    = WIDTH'(mask_above(int'(w_ptr_sel)));

  lsb_pick #(.WIDTH(WIDTH), .SIZE(SIZE)) u_pick_masked (
    .i_vec (Req & w_mask),
    .o_oh  (w_m_oh),
    .o_enc (w_m_enc),
    .o_any (w_m_any)
  );

  lsb_pick #(.WIDTH(WIDTH), .SIZE(SIZE)) u_pick_all (
    .i_vec (Req),
    .o_oh  (w_a_oh),
    .o_enc (w_a_enc),
    .o_any (w_a_any)
  );

  assign w_pick_oh  = w_m_any ? w_m_oh  : w_a_oh;
  assign w_pick_enc = w_m_any ? w_m_enc : w_a_enc;
  assign w_multi    = ($countones(Req) > 1);

  assign w_accept  = GntValid & GntReady;
  assign w_cap     = (r_cnt == CNT_W'(MAX_BURST - 1));
  assign w_release = w_accept & (Last | w_cap);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state  <= IDLE;
      r_ptr    <= SIZE'(WIDTH - 1);
      r_cnt    <= '0;
      GntValid <= 1'b0;
      Gnt      <= '0;
      GntEnc   <= '0;
      MultiReq <= 1'b0;
      ForceRel <= 1'b0;
    end else begin
      ForceRel <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_a_any) begin
            r_state  <= OFFER;
            GntValid <= 1'b1;
            Gnt      <= w_pick_oh;
            GntEnc   <= w_pick_enc;
            MultiReq <= w_multi;
          end
        end
        OFFER, BURST: begin
          if (w_release) begin
            r_ptr    <= GntEnc;
            r_cnt    <= '0;
            ForceRel <= w_cap & ~Last;
            if (w_a_any) begin
              r_state  <= OFFER;
              GntValid <= 1'b1;
              Gnt      <= w_pick_oh;
              GntEnc   <= w_pick_enc;
              MultiReq <= w_multi;
            end else begin
              r_state  <= IDLE;
              GntValid <= 1'b0;
              Gnt      <= '0;
              GntEnc   <= '0;
              MultiReq <= 1'b0;
            end
          end else if (w_accept) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= BURST;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed plus random checks of rr_burst_arbiter against a rotating-scan reference.
module tb_rr_burst_arbiter;

  localparam int W  = 8;
  localparam int SZ = 3;
  localparam int MB = 4;

  logic          Clk, RstN, Last, GntReady;
  logic [W-1:0]  Req;
  logic          GntValid, MultiReq, ForceRel;
  logic [W-1:0]  Gnt;
  logic [SZ-1:0] GntEnc;

  rr_burst_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .Clk      (Clk),
    .RstN     (RstN),
    .Req      (Req),
    .Last     (Last),
    .GntReady (GntReady),
    .GntValid (GntValid),
    .Gnt      (Gnt),
    .GntEnc   (GntEnc),
    .MultiReq (MultiReq),
    .ForceRel (ForceRel)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk, n_fail;

  // Reference: who holds the port, beats taken, last served index.
  bit m_valid, m_multi, m_force;
  int m_idx, m_ptr, m_beats;

  // Next winner is the first requester found walking upward from the last served one.
  function automatic int rr_pick(input logic [W-1:0] r, input int p);
    for (int k = 1; k <= W; k++) begin
      int i;
      i = (p + k) % W;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_multi = 0; m_force = 0;
    m_idx = 0; m_ptr = W - 1; m_beats = 0;
  endtask

  task automatic model_grant();
    m_idx   = rr_pick(Req, m_ptr);
    m_multi = ($countones(Req) > 1);
    m_valid = 1;
  endtask

  task automatic model_update();
    m_force = 0;
    if (!m_valid) begin
      if (Req != 0) model_grant();
    end else if (GntReady) begin
      m_beats++;
      if (Last || m_beats == MB) begin
        m_force = !Last;
        m_ptr   = m_idx;
        m_beats = 0;
        if (Req != 0) model_grant();
        else m_valid = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] exp_gnt;
    exp_gnt = m_valid ? (W'(1) << m_idx) : '0;
    chk("valid", 32'(GntValid), 32'(m_valid));
    chk("gnt",   32'(Gnt),      32'(exp_gnt));
    chk("force", 32'(ForceRel), 32'(m_force));
    if (m_valid) begin
      chk("enc",   32'(GntEnc),   32'(m_idx));
      chk("multi", 32'(MultiReq), 32'(m_multi));
    end
  endtask

  task automatic step();
    model_update();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  // Reset is asserted between edges and checked before any clock arrives.
  task automatic do_reset();
    RstN = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_enc", 32'(GntEnc), 32'd0);
    chk("rst_multi", 32'(MultiReq), 32'd0);
    @(posedge Clk);
    #1;
    RstN = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    Req = '0; Last = 1'b0; GntReady = 1'b0; RstN = 1'b1;
    #2;
    do_reset();

    // Round robin over requesters 2,5,7 with single-beat bursts.
    Req = 8'b1010_0100; Last = 1'b1; GntReady = 1'b1;
    step(); chk("rr_first", 32'(GntEnc), 32'd2);
    step(); chk("rr_second", 32'(GntEnc), 32'd5);
    step(); chk("rr_third", 32'(GntEnc), 32'd7);
    step(); chk("rr_wrap", 32'(GntEnc), 32'd2);
    step(); chk("rr_multi", 32'(MultiReq), 32'd1);

    // Mid-activity reset with everyone requesting, then restart from pointer WIDTH-1.
    Req = 8'hFF;
    do_reset();
    Req = 8'h0C;
    step(); chk("post_rst_gnt", 32'(Gnt), 32'h04);
    Req = 8'h00;
    step();

    // Backpressure: requester 3 drops its line while the offer is held.
    Req = 8'h08; GntReady = 1'b0; Last = 1'b0;
    step();
    Req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step(); chk("bp_hold", 32'(Gnt), 32'h08);
    end
    GntReady = 1'b1; Last = 1'b1;
    step(); chk("bp_idle", 32'(GntValid), 32'd0);

    // Burst cap alternates two requesters in 4-beat bursts.
    do_reset();
    Req = 8'h03; Last = 1'b0; GntReady = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("cap_force", 32'(ForceRel), 32'd1);
    chk("cap_next", 32'(GntEnc), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("cap_back", 32'(GntEnc), 32'd0);

    // Early Last on the second beat.
    do_reset();
    Req = 8'h11; Last = 1'b0; GntReady = 1'b1;
    step(); step();
    Last = 1'b1;
    step(); chk("early_next", 32'(GntEnc), 32'd4);
    chk("early_noforce", 32'(ForceRel), 32'd0);
    step();

    // Lone requester re-granted through the unmasked fallback.
    Req = 8'h80; Last = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("single_enc", 32'(GntEnc), 32'd7);
    chk("single_multi", 32'(MultiReq), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        Req = W'($urandom);
        do_reset();
      end
      case ($urandom_range(0, 3))
        0: Req = '0;
        1: Req = W'(1) << $urandom_range(0, W - 1);
        default: Req = W'($urandom);
      endcase
      Last     = ($urandom_range(0, 3) == 0);
      GntReady = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
